// File: rtl/dcache_nway_wt_if.sv
// CPU-side and memory-side bundles for the N-way write-through data cache.
// master drives requests, slave returns responses.
interface dcache_cpu_if #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
);
    logic                    req_valid;
    logic                    req_ready;
    logic                    req_we;
    logic [ADDR_W-1:0]       req_addr;
    logic [8*WORD_BYTES-1:0] req_wdata;
    logic [WORD_BYTES-1:0]   req_be;
    logic                    rsp_valid;
    logic [8*WORD_BYTES-1:0] rsp_rdata;
    logic                    flush_req;
    logic                    flush_done;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, flush_req,
        input  req_ready, rsp_valid, rsp_rdata, flush_done
    );
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, flush_req,
        output req_ready, rsp_valid, rsp_rdata, flush_done
    );
endinterface

interface dcache_mem_if #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4
);
    logic                    mem_req_valid;
    logic                    mem_req_ready;
    logic                    mem_req_we;
    logic [ADDR_W-1:0]       mem_req_addr;
    logic [8*WORD_BYTES-1:0] mem_req_wdata;
    logic [WORD_BYTES-1:0]   mem_req_be;
    logic                    mem_rsp_valid;
    logic [8*WORD_BYTES-1:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_we, mem_req_addr,
        output mem_req_wdata, mem_req_be,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
    modport slave (
        input  mem_req_valid, mem_req_we, mem_req_addr,
        input  mem_req_wdata, mem_req_be,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface

// File: rtl/dcache_nway_wt.sv
// N-way set-associative write-through, no-write-allocate data cache
// with round-robin victim pointers, line refill and invalidate walk.
module dcache_nway_wt #(
    parameter int ADDR_W     = 32,
    parameter int WORD_BYTES = 4,
    parameter int LINE_BYTES = 32,
    parameter int SETS       = 64,
    parameter int WAYS       = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    dcache_cpu_if.slave  cpu,
    dcache_mem_if.master mem
);
    localparam int DATA_W = 8 * WORD_BYTES;
    localparam int WPL    = LINE_BYTES / WORD_BYTES;
    localparam int WB_W   = $clog2(WORD_BYTES);
    localparam int OFF_W  = $clog2(LINE_BYTES);
    localparam int WI_W   = $clog2(WPL);
    localparam int IDX_W  = $clog2(SETS);
    localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
    localparam int WA_W   = ADDR_W - WB_W;
    localparam int WAY_W  = (WAYS > 1) ? $clog2(WAYS) : 1;

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] LOOKUP     = 3'd1;
    localparam logic [2:0] WRITE_REQ  = 3'd2;
    localparam logic [2:0] WRITE_WAIT = 3'd3;
    localparam logic [2:0] FILL_REQ   = 3'd4;
    localparam logic [2:0] FILL_WAIT  = 3'd5;
    localparam logic [2:0] FLUSH      = 3'd6;

    logic [2:0]            state_q;
    logic [WA_W-1:0]       addr_q;
    logic                  we_q;
    logic [DATA_W-1:0]     wdata_q;
    logic [WORD_BYTES-1:0] be_q;
    logic [WAYS-1:0]       valid_q [SETS];
    logic [WAY_W-1:0]      vptr_q  [SETS];
    logic [TAG_W-1:0]      tag_q   [WAYS][SETS];
    logic [DATA_W-1:0]     data_q  [WAYS][SETS*WPL];
    logic [WI_W-1:0]       wcnt_q;
    logic [IDX_W:0]        fcnt_q;
    logic [WAY_W-1:0]      vic_q;
    logic                  from_ptr_q;
    logic [DATA_W-1:0]     ld_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  rsp_q;

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic [WI_W-1:0]       word;
    logic [WAYS-1:0]       hit_vec;
    logic [WAY_W-1:0]      hit_way;
    logic [WAY_W-1:0]      inv_way;
    logic [WAY_W-1:0]      victim;
    logic [WAY_W-1:0]      nxt_ptr;
    logic                  any_inv;
    logic                  hit;
    logic                  fill_wr;
    logic                  fill_last;
    logic                  st_hit;
    logic                  wr_st;
    logic                  fill_st;

    assign word = addr_q[WI_W-1:0];
    assign idx  = addr_q[OFF_W-WB_W +: IDX_W];
    assign tag  = addr_q[WA_W-1 -: TAG_W];

    // Lowest-numbered way wins for both hit and invalid-victim selection
    always_comb begin
        hit_vec = '0;
        hit_way = '0;
        inv_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            hit_vec[w] = valid_q[idx][w] && (tag_q[w][idx] == tag);
            if (hit_vec[w]) hit_way = WAY_W'(w);
            if (!valid_q[idx][w]) inv_way = WAY_W'(w);
        end
    end

    assign hit     = |hit_vec;
    assign any_inv = ~&valid_q[idx];
    assign victim  = any_inv ? inv_way : vptr_q[idx];
    assign nxt_ptr = (vptr_q[idx] == WAY_W'(WAYS - 1)) ? '0
                   : vptr_q[idx] + WAY_W'(1);

    assign fill_wr   = (state_q == FILL_WAIT) && mem.mem_rsp_valid;
    assign fill_last = fill_wr && (wcnt_q == WI_W'(WPL - 1));
    assign st_hit    = (state_q == LOOKUP) && we_q && hit;
    assign wr_st     = (state_q == WRITE_REQ);
    assign fill_st   = (state_q == FILL_REQ);

    assign cpu.req_ready  = rst_n && (state_q == IDLE) && !cpu.flush_req;
    assign cpu.rsp_valid  = rsp_q;
    assign cpu.rsp_rdata  = rdata_q;
    assign cpu.flush_done = (state_q == FLUSH)
                         && (fcnt_q == (IDX_W+1)'(SETS));

    assign mem.mem_req_valid = wr_st || fill_st;
    assign mem.mem_req_we    = wr_st;
    assign mem.mem_req_wdata = wr_st ? wdata_q : '0;
    assign mem.mem_req_be    = wr_st ? be_q : '0;
    assign mem.mem_req_addr  =
        wr_st   ? {addr_q, {WB_W{1'b0}}} :
        fill_st ? {addr_q[WA_W-1:WI_W], wcnt_q, {WB_W{1'b0}}} :
                  '0;

    // Line storage and tags are not reset; valid bits guard them
    always_ff @(posedge clk) begin
        if (fill_wr)
            data_q[vic_q][{idx, wcnt_q}] <= mem.mem_rsp_rdata;
        if (fill_last)
            tag_q[vic_q][idx] <= tag;
        if (st_hit) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
                if (be_q[b])
                    data_q[hit_way][{idx, word}][8*b +: 8] <= wdata_q[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            be_q       <= '0;
            wcnt_q     <= '0;
            fcnt_q     <= '0;
            vic_q      <= '0;
            from_ptr_q <= 1'b0;
            ld_q       <= '0;
            rdata_q    <= '0;
            rsp_q      <= 1'b0;
            for (int s = 0; s < SETS; s++) begin
                valid_q[s] <= '0;
                vptr_q[s]  <= '0;
            end
        end else begin
            rsp_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (cpu.flush_req) begin
                        fcnt_q  <= '0;
                        state_q <= FLUSH;
                    end else if (cpu.req_valid) begin
                        addr_q  <= cpu.req_addr[ADDR_W-1:WB_W];
                        we_q    <= cpu.req_we;
                        wdata_q <= cpu.req_wdata;
                        be_q    <= cpu.req_be;
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (we_q) begin
                        state_q <= WRITE_REQ;
                    end else if (hit) begin
                        rsp_q   <= 1'b1;
                        rdata_q <= data_q[hit_way][{idx, word}];
                        state_q <= IDLE;
                    end else begin
                        vic_q               <= victim;
                        from_ptr_q          <= !any_inv;
                        valid_q[idx][victim] <= 1'b0;
                        wcnt_q              <= '0;
                        state_q             <= FILL_REQ;
                    end
                end
                WRITE_REQ: begin
                    if (mem.mem_req_ready) state_q <= WRITE_WAIT;
                end
                WRITE_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        rsp_q   <= 1'b1;
                        rdata_q <= '0;
                        state_q <= IDLE;
                    end
                end
                FILL_REQ: begin
                    if (mem.mem_req_ready) state_q <= FILL_WAIT;
                end
                FILL_WAIT: begin
                    if (mem.mem_rsp_valid) begin
                        if (wcnt_q == word) ld_q <= mem.mem_rsp_rdata;
                        if (fill_last) begin
                            valid_q[idx][vic_q] <= 1'b1;
                            if (from_ptr_q) vptr_q[idx] <= nxt_ptr;
                            rsp_q   <= 1'b1;
                            rdata_q <= (wcnt_q == word) ? mem.mem_rsp_rdata
                                                        : ld_q;
                            state_q <= IDLE;
                        end else begin
                            wcnt_q  <= wcnt_q + WI_W'(1);
                            state_q <= FILL_REQ;
                        end
                    end
                end
                FLUSH: begin
                    if (fcnt_q == (IDX_W+1)'(SETS)) begin
                        state_q <= IDLE;
                    end else begin
                        valid_q[fcnt_q[IDX_W-1:0]] <= '0;
                        vptr_q[fcnt_q[IDX_W-1:0]]  <= '0;
                        fcnt_q <= fcnt_q + (IDX_W+1)'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dcache_nway_wt.sv
// Directed bench for dcache_nway_wt: fills, hits, stores, replacement,
// memory backpressure and the invalidate walk against a word memory model.
module tb_dcache_nway_wt;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dcache_cpu_if cif ();
    dcache_mem_if mif ();

    dcache_nway_wt dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cpu  (cif.slave),
        .mem  (mif.master)
    );

    int checks = 0;
    int errors = 0;

    logic [31:0] mem_arr [4096];
    logic        mem_ready;
    logic        m_rsp_valid;
    logic [31:0] m_rsp_rdata;
    int          rd_cnt = 0;
    int          wr_cnt = 0;
    logic [31:0] rd_log [$];
    logic [31:0] lw_addr;
    logic [31:0] lw_data;
    logic [3:0]  lw_be;

    assign mif.mem_req_ready = mem_ready;
    assign mif.mem_rsp_valid = m_rsp_valid;
    assign mif.mem_rsp_rdata = m_rsp_rdata;

    initial begin
        for (int i = 0; i < 4096; i++) mem_arr[i] = 32'h1000_0000 + 32'(i * 4);
    end

    always @(posedge clk) begin
        m_rsp_valid <= 1'b0;
        if (rst_n && mif.mem_req_valid && mif.mem_req_ready) begin
            if (mif.mem_req_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (mif.mem_req_be[b])
                        mem_arr[mif.mem_req_addr[13:2]][8*b +: 8] =
                            mif.mem_req_wdata[8*b +: 8];
                end
                wr_cnt++;
                lw_addr = mif.mem_req_addr;
                lw_data = mif.mem_req_wdata;
                lw_be   = mif.mem_req_be;
            end else begin
                m_rsp_rdata <= mem_arr[mif.mem_req_addr[13:2]];
                rd_cnt++;
                rd_log.push_back(mif.mem_req_addr);
            end
            m_rsp_valid <= 1'b1;
        end
    end

    task automatic do_req(input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be,
                          output logic [31:0] rdata, output int lat,
                          output int nrd, output int nwr);
        int r0, w0, n;
        r0 = rd_cnt;
        w0 = wr_cnt;
        @(negedge clk);
        cif.req_valid = 1'b1;
        cif.req_we    = we;
        cif.req_addr  = addr;
        cif.req_wdata = wdata;
        cif.req_be    = be;
        n = 0;
        while (cif.req_ready !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL accept: req_ready low for 100 cycles, addr %h", addr);
        end
        @(posedge clk);
        #1 cif.req_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (cif.rsp_valid !== 1'b1 && lat < 500);
        checks++;
        if (lat >= 500) begin
            errors++;
            $display("FAIL response: no rsp_valid within 500 cycles, addr %h", addr);
        end
        rdata = cif.rsp_rdata;
        nrd = rd_cnt - r0;
        nwr = wr_cnt - w0;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        cif.req_valid = 1'b0;
        cif.req_we = 1'b0;
        cif.req_addr = '0;
        cif.req_wdata = '0;
        cif.req_be = '0;
        cif.flush_req = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (cif.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_ready: got %b want 0", cif.req_ready);
        end
        checks++;
        if (cif.rsp_valid !== 1'b0 || cif.rsp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_rsp: got %b/%h want 0/0",
                     cif.rsp_valid, cif.rsp_rdata);
        end
        checks++;
        if (cif.flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush_done: got %b want 0", cif.flush_done);
        end
        checks++;
        if (mif.mem_req_valid !== 1'b0 || mif.mem_req_addr !== 32'h0 ||
            mif.mem_req_we !== 1'b0 || mif.mem_req_be !== 4'h0) begin
            errors++;
            $display("FAIL reset_mem: got v%b a%h want v0 a0",
                     mif.mem_req_valid, mif.mem_req_addr);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (cif.req_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_ready: got %b want 1", cif.req_ready);
        end
    endtask

    task automatic test_load_miss();
        logic [31:0] rd;
        int lat, nrd, nwr;
        bit ok;
        rd_log.delete();
        do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8 || nwr != 0) begin
            errors++;
            $display("FAIL miss_reads: got %0d rd %0d wr want 8/0", nrd, nwr);
        end
        ok = (rd_log.size() == 8);
        for (int k = 0; k < rd_log.size(); k++)
            if (rd_log[k] !== 32'h100 + 32'(4 * k)) ok = 0;
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL miss_order: got %0d reads, first %h want 0x100..0x11c",
                     rd_log.size(), rd_log.size() ? rd_log[0] : 32'hx);
        end
        checks++;
        if (rd !== 32'h1000_0100) begin
            errors++;
            $display("FAIL miss_data: got %h want 10000100", rd);
        end
    endtask

    task automatic test_load_hit();
        logic [31:0] rd;
        int lat, nrd, nwr;
        do_req(1'b0, 32'h100, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (lat != 2 || nrd != 0) begin
            errors++;
            $display("FAIL hit_lat: got lat %0d reads %0d want 2/0", lat, nrd);
        end
        checks++;
        if (rd !== 32'h1000_0100) begin
            errors++;
            $display("FAIL hit_data: got %h want 10000100", rd);
        end
        do_req(1'b0, 32'h11C, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (lat != 2 || nrd != 0 || rd !== 32'h1000_011C) begin
            errors++;
            $display("FAIL hit_last_word: got lat %0d rd %0d data %h want 2/0/1000011c",
                     lat, nrd, rd);
        end
    endtask

    task automatic test_store_hit();
        logic [31:0] rd;
        int lat, nrd, nwr;
        do_req(1'b1, 32'h104, 32'hDEAD_BEEF, 4'b0011, rd, lat, nrd, nwr);
        checks++;
        if (nwr != 1 || nrd != 0) begin
            errors++;
            $display("FAIL store_hit_traffic: got wr %0d rd %0d want 1/0", nwr, nrd);
        end
        checks++;
        if (lw_addr !== 32'h104 || lw_be !== 4'b0011 || lw_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL store_hit_fields: got a%h be%b d%h want 104/0011/deadbeef",
                     lw_addr, lw_be, lw_data);
        end
        checks++;
        if (rd !== 32'h0) begin
            errors++;
            $display("FAIL store_rdata: got %h want 0", rd);
        end
        do_req(1'b0, 32'h104, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (rd !== 32'h1000_BEEF || lat != 2 || nrd != 0) begin
            errors++;
            $display("FAIL store_merge: got %h lat %0d rd %0d want 1000beef/2/0",
                     rd, lat, nrd);
        end
    endtask

    task automatic test_store_miss();
        logic [31:0] rd;
        int lat, nrd, nwr;
        do_req(1'b1, 32'h2000, 32'h1234_5678, 4'hF, rd, lat, nrd, nwr);
        checks++;
        if (nwr != 1 || nrd != 0) begin
            errors++;
            $display("FAIL store_miss_traffic: got wr %0d rd %0d want 1/0", nwr, nrd);
        end
        do_req(1'b0, 32'h2000, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8 || rd !== 32'h1234_5678) begin
            errors++;
            $display("FAIL store_no_alloc: got rd %0d data %h want 8/12345678",
                     nrd, rd);
        end
    endtask

    task automatic test_replacement();
        logic [31:0] rd;
        int lat, nrd, nwr;
        apply_reset();
        do_req(1'b0, 32'h0000, 32'h0, 4'h0, rd, lat, nrd, nwr);
        do_req(1'b0, 32'h0800, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8 || rd !== 32'h1000_0800) begin
            errors++;
            $display("FAIL repl_second: got rd %0d data %h want 8/10000800", nrd, rd);
        end
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8 || rd !== 32'h1000_1000) begin
            errors++;
            $display("FAIL repl_third: got rd %0d data %h want 8/10001000", nrd, rd);
        end
        do_req(1'b0, 32'h0800, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 0 || lat != 2 || rd !== 32'h1000_0800) begin
            errors++;
            $display("FAIL repl_keep_way1: got rd %0d lat %0d data %h want 0/2/10000800",
                     nrd, lat, rd);
        end
        do_req(1'b0, 32'h0000, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8 || rd !== 32'h1000_0000) begin
            errors++;
            $display("FAIL repl_evicted_first: got rd %0d data %h want 8/10000000",
                     nrd, rd);
        end
        do_req(1'b0, 32'h1000, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 0 || lat != 2) begin
            errors++;
            $display("FAIL repl_ptr_way1: got rd %0d lat %0d want 0/2", nrd, lat);
        end
        do_req(1'b0, 32'h0800, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8) begin
            errors++;
            $display("FAIL repl_ptr_wrap: got rd %0d want 8", nrd);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] rd, a0;
        logic        we0;
        logic [3:0]  be0;
        int lat, nrd, nwr, n;
        bit stable, ok;
        mem_ready = 1'b0;
        rd_log.delete();
        n = 0;
        stable = 1;
        fork
            do_req(1'b0, 32'h300, 32'h0, 4'h0, rd, lat, nrd, nwr);
            begin
                @(negedge clk);
                while (mif.mem_req_valid !== 1'b1 && n < 50) begin
                    @(negedge clk);
                    n++;
                end
                a0  = mif.mem_req_addr;
                we0 = mif.mem_req_we;
                be0 = mif.mem_req_be;
                repeat (5) begin
                    @(negedge clk);
                    if (mif.mem_req_valid !== 1'b1 || mif.mem_req_addr !== a0 ||
                        mif.mem_req_we !== we0 || mif.mem_req_be !== be0)
                        stable = 0;
                end
                mem_ready = 1'b1;
            end
        join
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL bp_issue: got no mem_req_valid in 50 cycles want request");
        end
        checks++;
        if (!stable || a0 !== 32'h300 || we0 !== 1'b0 || be0 !== 4'h0) begin
            errors++;
            $display("FAIL bp_stable: got stable %0d a%h we%b be%b want 1/300/0/0",
                     stable, a0, we0, be0);
        end
        ok = (rd_log.size() == 8);
        for (int k = 0; k < rd_log.size(); k++)
            if (rd_log[k] !== 32'h300 + 32'(4 * k)) ok = 0;
        checks++;
        if (!ok || nrd != 8) begin
            errors++;
            $display("FAIL bp_reads: got %0d reads want 8 in order 0x300..0x31c", nrd);
        end
        checks++;
        if (rd !== 32'h1000_0300) begin
            errors++;
            $display("FAIL bp_data: got %h want 10000300", rd);
        end
    endtask

    task automatic test_flush();
        logic [31:0] rd;
        int lat, nrd, nwr, n;
        bit saw_rsp, busy_ready;
        do_req(1'b0, 32'h300, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (lat != 2 || nrd != 0) begin
            errors++;
            $display("FAIL flush_prehit: got lat %0d rd %0d want 2/0", lat, nrd);
        end
        @(negedge clk);
        cif.flush_req = 1'b1;
        cif.req_valid = 1'b1;
        cif.req_we    = 1'b0;
        cif.req_addr  = 32'h300;
        #1;
        checks++;
        if (cif.req_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_priority: got req_ready %b want 0", cif.req_ready);
        end
        n = 0;
        saw_rsp = 0;
        busy_ready = 0;
        do begin
            @(negedge clk);
            n++;
            if (cif.rsp_valid === 1'b1) saw_rsp = 1;
            if (cif.req_ready === 1'b1) busy_ready = 1;
        end while (cif.flush_done !== 1'b1 && n < 200);
        cif.flush_req = 1'b0;
        cif.req_valid = 1'b0;
        checks++;
        if (n != 65) begin
            errors++;
            $display("FAIL flush_latency: got %0d cycles want 65", n);
        end
        checks++;
        if (saw_rsp || busy_ready) begin
            errors++;
            $display("FAIL flush_quiet: got rsp %0d ready %0d want 0/0",
                     saw_rsp, busy_ready);
        end
        @(negedge clk);
        checks++;
        if (cif.flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_pulse: got flush_done %b want 0", cif.flush_done);
        end
        do_req(1'b0, 32'h300, 32'h0, 4'h0, rd, lat, nrd, nwr);
        checks++;
        if (nrd != 8 || rd !== 32'h1000_0300) begin
            errors++;
            $display("FAIL flush_invalidated: got rd %0d data %h want 8/10000300",
                     nrd, rd);
        end
    endtask

    initial begin
        test_reset();
        test_load_miss();
        test_load_hit();
        test_store_hit();
        test_store_miss();
        test_replacement();
        test_backpressure();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
